// File: rtl/ac_agc_pkg.sv
// Shared constants and types for the AC-path automatic gain control.
package ac_agc_pkg;

    // Shift amounts that set the dead band and the gain step sizes.
    localparam int THR_SHIFT = 3;   // dead band is Target +/- Target/8
    localparam int DEC_SHIFT = 3;   // decrease step is Gain/8 (at least 1)
    localparam int INC_SHIFT = 4;   // increase step is Gain/16 + 1

    // Default fraction width and the matching unity gain.
    localparam int DEF_F      = 8;
    localparam int UNITY_GAIN = 1 << DEF_F;

    // Gain controller states.
    typedef enum logic {
        GS_IDLE,
        GS_EVAL
    } gain_state_t;

    // Unity gain for an arbitrary number of fraction bits.
    function automatic int unity_gain(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/ac_agc_peak_window.sv
// Peak detector: |Input| tracked over windows of 2^win clocks.
// Peak is refreshed on the last clock of each window (that sample
// included) and Done pulses for one clock right after the refresh.
module ac_agc_peak_window
    import ac_agc_pkg::*;
#(
    parameter int n   = 18,
    parameter int win = 16
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic [n-1:0] Input,
    output logic [n-1:0] Peak,
    output logic         Done
);

    localparam logic [n-1:0]   MOST_NEG = {1'b1, {(n-1){1'b0}}};
    localparam logic [n-1:0]   MOST_POS = {1'b0, {(n-1){1'b1}}};
    localparam logic [win-1:0] CNT_ONE  = {{(win-1){1'b0}}, 1'b1};

    logic [win-1:0] count;
    logic [n-1:0]   mag;
    logic [n-1:0]   run_max;
    logic [n-1:0]   max_now;
    logic           win_end;

    // Magnitude of the current sample; the most negative code folds onto
    // the most positive so the result always fits in n unsigned bits.
    always_comb begin
        mag = Input;
        if (Input == MOST_NEG) begin
            mag = MOST_POS;
        end else if (Input[n-1]) begin
            mag = -Input;
        end
    end

    // Running maximum including the current sample, and window end decode.
    always_comb begin
        max_now = (mag > run_max) ? mag : run_max;
        win_end = &count;
    end

    // Window counter, running maximum, and peak latch.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            count   <= '0;
            run_max <= '0;
            Peak    <= '0;
            Done    <= 1'b0;
        end else begin
            count <= count + CNT_ONE;
            Done  <= win_end;
            if (win_end) begin
                Peak    <= max_now;
                run_max <= '0;
            end else begin
                run_max <= max_now;
            end
        end
    end

endmodule

// File: rtl/ac_agc.sv
// Automatic gain control on the AC component.
// Gain FSM states:
//   state   | meaning
//   GS_IDLE | waiting for a window to complete
//   GS_EVAL | gain just written from the latest Peak; Update is high
// Output = Input*Gain/2^f, rounded half-up, saturated, two clocks after Input.
module ac_agc
    import ac_agc_pkg::*;
#(
    parameter int n      = 18,
    parameter int g      = 12,
    parameter int f      = 8,
    parameter int win    = 16,
    parameter int Target = 2 ** (n - 2)
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic [n-1:0] Input,
    output logic [n-1:0] Output,
    output logic [g-1:0] Gain,
    output logic [n-1:0] Peak,
    output logic         Update,
    output logic         Clip
);

    localparam int PW = n + g + 1;

    localparam logic [g-1:0]          UNITY  = g'(unity_gain(f));
    localparam logic [g-1:0]          G_ONE  = {{(g-1){1'b0}}, 1'b1};
    localparam logic [g-1:0]          G_MAX  = {g{1'b1}};
    localparam logic [n:0]            THR_HI = (n+1)'(Target + (Target >>> THR_SHIFT));
    localparam logic [n:0]            THR_LO = (n+1)'(Target - (Target >>> THR_SHIFT));
    localparam logic signed [PW-1:0]  ROUND  = PW'(unity_gain(f) / 2);
    localparam logic signed [PW-1:0]  SAT_HI = PW'((2 ** (n - 1)) - 1);
    localparam logic signed [PW-1:0]  SAT_LO = ~SAT_HI;

    gain_state_t state;
    gain_state_t state_next;

    logic [g-1:0]          gain_q;
    logic [g-1:0]          gain_next;
    logic [g-1:0]          gain_dec;
    logic [g-1:0]          gain_inc;
    logic [g-1:0]          dec_step;
    logic [g:0]            inc_sum;
    logic [n:0]            peak_ext;
    logic                  win_done;

    logic signed [PW-1:0]  in_ext;
    logic signed [PW-1:0]  gain_ext;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  rounded;
    logic signed [PW-1:0]  scaled;
    logic [n-1:0]          sat_val;
    logic                  sat_clip;

    ac_agc_peak_window #(
        .n   (n),
        .win (win)
    ) u_peak_window (
        .Clk    (Clk),
        .nReset (nReset),
        .Input  (Input),
        .Peak   (Peak),
        .Done   (win_done)
    );

    assign in_ext   = {{(g+1){Input[n-1]}}, Input};
    assign gain_ext = {{(n+1){1'b0}}, gain_q};

    // Stage 1: product with the gain in force this cycle, so a gain write
    // never disturbs a sample already captured here.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            prod <= '0;
        end else begin
            prod <= in_ext * gain_ext;
        end
    end

    // Round half-up, drop the fraction bits, and clamp to the n-bit range.
    always_comb begin
        rounded  = prod + ROUND;
        scaled   = rounded >>> f;
        sat_val  = scaled[n-1:0];
        sat_clip = 1'b0;
        if (scaled > SAT_HI) begin
            sat_val  = SAT_HI[n-1:0];
            sat_clip = 1'b1;
        end else if (scaled < SAT_LO) begin
            sat_val  = SAT_LO[n-1:0];
            sat_clip = 1'b1;
        end
    end

    // Stage 2: registered output and its clip flag, kept in step.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Output <= '0;
            Clip   <= 1'b0;
        end else begin
            Output <= sat_val;
            Clip   <= sat_clip;
        end
    end

    // Candidate gains for the over- and under-target cases; gain never hits 0.
    always_comb begin
        peak_ext = {1'b0, Peak};
        dec_step = gain_q >> DEC_SHIFT;
        if (dec_step == '0) begin
            dec_step = G_ONE;
        end
        gain_dec = (gain_q > dec_step) ? (gain_q - dec_step) : G_ONE;
        inc_sum  = {1'b0, gain_q} + {1'b0, (gain_q >> INC_SHIFT)} + {{g{1'b0}}, 1'b1};
        gain_inc = inc_sum[g] ? G_MAX : inc_sum[g-1:0];
    end

    // Gain FSM next state: write the gain the clock after a new Peak lands.
    always_comb begin
        state_next = state;
        gain_next  = gain_q;
        case (state)
            GS_IDLE: begin
                if (win_done) begin
                    state_next = GS_EVAL;
                    if (peak_ext > THR_HI) begin
                        gain_next = gain_dec;
                    end else if (peak_ext < THR_LO) begin
                        gain_next = gain_inc;
                    end
                end
            end
            GS_EVAL: begin
                state_next = GS_IDLE;
            end
            default: begin
                state_next = GS_IDLE;
            end
        endcase
    end

    // Gain FSM state and gain register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state  <= GS_IDLE;
            gain_q <= UNITY;
        end else begin
            state  <= state_next;
            gain_q <= gain_next;
        end
    end

    assign Gain   = gain_q;
    assign Update = (state == GS_EVAL);

endmodule

// File: tb/tb_ac_agc.sv
// Scoreboard bench for ac_agc (n=18, g=12, f=8, win=6, Target=65536).
module tb_ac_agc;

    localparam int N = 18;
    localparam int G = 12;
    localparam int F = 8;
    localparam int W = 6;

    logic         Clk    = 1'b0;
    logic         nReset = 1'b0;
    logic [N-1:0] Input  = '0;
    logic [N-1:0] Output;
    logic [G-1:0] Gain;
    logic [N-1:0] Peak;
    logic         Update;
    logic         Clip;

    ac_agc #(
        .n      (N),
        .g      (G),
        .f      (F),
        .win    (W),
        .Target (65536)
    ) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .Input  (Input),
        .Output (Output),
        .Gain   (Gain),
        .Peak   (Peak),
        .Update (Update),
        .Clip   (Clip)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        longint out;
        longint clip;
    } out_t;

    typedef struct {
        int     due;
        longint gain;
        longint peak;
    } upd_t;

    out_t out_q[$];
    upd_t upd_q[$];
    out_t oe;
    upd_t ue;

    int total = 0;
    int bad   = 0;

    // reference model state
    int     mc;
    longint mm;
    longint mpeak;
    longint mg;
    bit     pend;
    int     rel_cyc   = 0;
    int     first_upd = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint mag_of(input longint x);
        if (x == -131072) return 131071;
        return (x < 0) ? -x : x;
    endfunction

    function automatic longint next_gain(input longint gv, input longint pk);
        longint step;
        if (pk > 73728) begin
            step = gv >> 3;
            if (step == 0) step = 1;
            return (gv > step) ? gv - step : 1;
        end else if (pk < 57344) begin
            step = gv + (gv >> 4) + 1;
            return (step > 4095) ? 4095 : step;
        end
        return gv;
    endfunction

    function automatic longint wave(input int i, input longint amp);
        return (((i / 4) % 2) == 1) ? -amp : amp;
    endfunction

    // Present one sample this cycle and predict everything it implies.
    task automatic apply(input longint x);
        longint p, r, a, m2, c;
        Input = x[N-1:0];
        p = x * mg;
        r = (p + 128) >>> 8;
        c = 0;
        if (r > 131071) begin
            r = 131071;
            c = 1;
        end else if (r < -131072) begin
            r = -131072;
            c = 1;
        end
        out_q.push_back('{cyc + 2, r, c});
        if (pend) begin
            mg   = next_gain(mg, mpeak);
            upd_q.push_back('{cyc + 1, mg, mpeak});
            pend = 1'b0;
        end
        a  = mag_of(x);
        m2 = (a > mm) ? a : mm;
        if (mc == 63) begin
            mpeak = m2;
            mm    = 0;
            pend  = 1'b1;
        end else begin
            mm = m2;
        end
        mc = (mc + 1) % 64;
    endtask

    task automatic drive(input longint x);
        @(negedge Clk);
        apply(x);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        nReset = 1'b0;
        Input  = '0;
        out_q.delete();
        upd_q.delete();
        #1;
        chk("rst_output", $signed(Output), 0);
        chk("rst_gain", Gain, 256);
        chk("rst_peak", Peak, 0);
        chk("rst_update", Update, 0);
        chk("rst_clip", Clip, 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic release_with(input longint x);
        @(negedge Clk);
        nReset    = 1'b1;
        mc        = 0;
        mm        = 0;
        mpeak     = 0;
        mg        = 256;
        pend      = 1'b0;
        first_upd = -1;
        rel_cyc   = cyc;
        apply(x);
    endtask

    // Monitor: compare whatever the DUT presents against the queued predictions.
    always @(negedge Clk) begin
        if (nReset) begin
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                oe = out_q.pop_front();
                chk("output", $signed(Output), oe.out);
                chk("clip", Clip, oe.clip);
            end
            if (Update) begin
                if (first_upd < 0) first_upd = cyc;
                chk("gain_nonzero", (Gain != 0), 1);
                if (upd_q.size() > 0 && upd_q[0].due == cyc) begin
                    ue = upd_q.pop_front();
                    chk("upd_gain", Gain, ue.gain);
                    chk("upd_peak", Peak, ue.peak);
                end else begin
                    chk("update_unexpected", Update, 0);
                end
            end else if (upd_q.size() > 0 && upd_q[0].due == cyc) begin
                void'(upd_q.pop_front());
                chk("update_missing", Update, 1);
            end
        end
    end

    initial begin
        // power-on reset state
        repeat (3) @(negedge Clk);
        #1;
        chk("por_output", $signed(Output), 0);
        chk("por_gain", Gain, 256);
        chk("por_peak", Peak, 0);
        chk("por_update", Update, 0);
        chk("por_clip", Clip, 0);

        // 1: constant 1000 appears two clocks later at unity gain
        release_with(1000);
        drive(1000);
        drive(1000);
        #1;
        chk("t1_output", $signed(Output), 1000);
        chk("t1_clip", Clip, 0);
        chk("t1_gain", Gain, 256);
        repeat (70) drive(1000);

        // 2: a single full-scale negative sample sets Peak and cuts the gain
        do_reset();
        release_with(-131072);
        repeat (64) drive(0);
        #1;
        chk("t2_peak", Peak, 131071);
        chk("t2_gain_before", Gain, 256);
        chk("t2_update_before", Update, 0);
        drive(0);
        #1;
        chk("t2_update", Update, 1);
        chk("t2_gain", Gain, 224);
        repeat (5) drive(0);

        // 3: small square wave raises the gain, in-band square wave holds it
        do_reset();
        release_with(wave(0, 16384));
        for (int i = 1; i < 128; i++) begin
            drive(wave(i, 16384));
            if (i == 65) begin
                #1;
                chk("t3_gain_first", Gain, 273);
            end
        end
        for (int i = 128; i < 258; i++) begin
            drive(wave(i, 65536));
            if (i == 129 || i == 257) begin
                #1;
                chk("t3_gain_held", Gain, 291);
            end
        end
        #1;
        chk("t3_peak_inband", Peak, 65536);

        // 4: quiet windows push the gain past 4x, then large inputs clip
        repeat (24 * 64) drive(0);
        #1;
        chk("t4_gain_above_1024", (Gain > 1024), 1);
        drive(100000);
        drive(-100000);
        drive(0);
        #1;
        chk("t4_pos_sat", $signed(Output), 131071);
        chk("t4_pos_clip", Clip, 1);
        drive(0);
        #1;
        chk("t4_neg_sat", $signed(Output), -131072);
        chk("t4_neg_clip", Clip, 1);

        // 5: sustained full scale walks the gain down to its floor of 1
        repeat (80 * 64) drive(131071);
        #1;
        chk("t5_peak", Peak, 131071);
        chk("t5_gain_floor", Gain, 1);

        // 6: reset mid-window restores everything; first update 65 clocks on
        repeat (20) drive(5000);
        do_reset();
        release_with(5000);
        repeat (70) drive(5000);
        chk("t6_update_delay", first_upd - rel_cyc, 65);
        #1;
        chk("t6_gain", Gain, 273);

        repeat (3) drive(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
